// File: rtl/seg7_scan_ctrl.sv
// N-digit multiplexed 7-segment scan controller with frame-synchronous shadow
// latching, leading-zero blanking, dead time between digits and selectable
// output polarity. Single clock domain; prescalers produce clock enables.
module seg7_scan_ctrl #(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned SCAN_HZ     = 1000,
  parameter int unsigned FRESH_HZ    = 1,
  parameter int unsigned DEAD_CYC    = 2,
  parameter int unsigned SEG_ACT_LOW = 1,
  parameter int unsigned COM_ACT_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] i_data,
  input  logic [N_DIGITS-1:0]   i_dp,
  input  logic                  i_blank_lz,
  input  logic                  i_update,
  output logic [6:0]            smg_seg,
  output logic                  smg_dp,
  output logic [N_DIGITS-1:0]   smg_com,
  output logic                  o_frame
);

  localparam int unsigned SCAN_DIV  = CLK_HZ / SCAN_HZ;
  localparam int unsigned FRESH_DIV = CLK_HZ / FRESH_HZ;
  localparam int unsigned SW        = $clog2(SCAN_DIV);
  localparam int unsigned FW        = $clog2(FRESH_DIV);
  localparam int unsigned IW        = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRESH_LAST = FW'(FRESH_DIV - 1);
  localparam logic [SW-1:0] DEAD_LAST  = SW'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  localparam logic [N_DIGITS-1:0] COM_OFF = (COM_ACT_LOW != 0) ? '1 : '0;
  localparam logic [6:0]          SEG_OFF = (SEG_ACT_LOW != 0) ? '1 : '0;
  localparam logic                DP_OFF  = (SEG_ACT_LOW != 0);

  // S_IDLE only exists between reset and the first scan_tick so that the
  // first digit shown after reset is digit 0.
  typedef enum logic [1:0] {
    S_IDLE,
    S_DEAD,
    S_ON
  } state_t;

  state_t                  state;
  logic [SW-1:0]           scan_cnt;
  logic [FW-1:0]           fresh_cnt;
  logic [SW-1:0]           dead_cnt;
  logic [IW-1:0]           idx;
  logic                    latch_req;
  logic [4*N_DIGITS-1:0]   shadow_data;
  logic [N_DIGITS-1:0]     shadow_dp;

  logic                    scan_tick;
  logic                    fresh_tick;
  logic                    frame_tick;
  logic                    req_now;

  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic                    lz_run;
  logic [N_DIGITS-1:0]     com_hot;
  logic [6:0]              seg_hi;

  assign scan_tick  = (scan_cnt == SCAN_LAST);
  assign fresh_tick = (fresh_cnt == FRESH_LAST);
  assign frame_tick = scan_tick && (idx == IDX_LAST);
  assign req_now    = latch_req | fresh_tick | i_update;

  // Scan and refresh prescalers
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt  <= '0;
      fresh_cnt <= '0;
    end else begin
      scan_cnt  <= scan_tick  ? '0 : scan_cnt + 1'b1;
      fresh_cnt <= fresh_tick ? '0 : fresh_cnt + 1'b1;
    end
  end

  // Digit FSM: every scan_tick advances the digit and opens a dead window
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      dead_cnt <= '0;
    end else if (scan_tick) begin
      if (state != S_IDLE) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
      dead_cnt <= '0;
      state    <= (DEAD_CYC == 0) ? S_ON : S_DEAD;
    end else if (state == S_DEAD) begin
      if (dead_cnt == DEAD_LAST) begin
        state <= S_ON;
      end else begin
        dead_cnt <= dead_cnt + 1'b1;
      end
    end
  end

  // Shadow register loads only at a frame boundary; requests merge until then
  always_ff @(posedge clk) begin
    if (rst) begin
      latch_req   <= 1'b0;
      shadow_data <= '0;
      shadow_dp   <= '0;
      o_frame     <= 1'b0;
    end else begin
      o_frame <= frame_tick & req_now;
      if (frame_tick && req_now) begin
        shadow_data <= i_data;
        shadow_dp   <= i_dp;
        latch_req   <= 1'b0;
      end else begin
        latch_req <= req_now;
      end
    end
  end

  // Active-digit select and leading-zero blanking, walking from the top digit down
  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    com_hot   = '0;
    lz_run    = i_blank_lz;
    for (int unsigned j = 0; j < N_DIGITS; j++) begin
      lz_run = lz_run && (shadow_data[4*(N_DIGITS-1-j) +: 4] == 4'h0)
                      && !shadow_dp[N_DIGITS-1-j];
      if (idx == IW'(N_DIGITS - 1 - j)) begin
        cur_nib   = shadow_data[4*(N_DIGITS-1-j) +: 4];
        cur_dp    = shadow_dp[N_DIGITS-1-j];
        cur_blank = lz_run && (j != N_DIGITS - 1);
        com_hot[N_DIGITS-1-j] = 1'b1;
      end
    end
  end

  // Hex to segment decode, active-high {g,f,e,d,c,b,a}
  always_comb begin
    seg_hi = 7'h00;
    case (cur_nib)
      4'h0: seg_hi = 7'h3F;
      4'h1: seg_hi = 7'h06;
      4'h2: seg_hi = 7'h5B;
      4'h3: seg_hi = 7'h4F;
      4'h4: seg_hi = 7'h66;
      4'h5: seg_hi = 7'h6D;
      4'h6: seg_hi = 7'h7D;
      4'h7: seg_hi = 7'h07;
      4'h8: seg_hi = 7'h7F;
      4'h9: seg_hi = 7'h6F;
      4'hA: seg_hi = 7'h77;
      4'hB: seg_hi = 7'h7C;
      4'hC: seg_hi = 7'h39;
      4'hD: seg_hi = 7'h5E;
      4'hE: seg_hi = 7'h79;
      4'hF: seg_hi = 7'h71;
      default: seg_hi = 7'h00;
    endcase
  end

  // Registered pin drivers; everything dark outside the ON state
  always_ff @(posedge clk) begin
    if (rst) begin
      smg_com <= COM_OFF;
      smg_seg <= SEG_OFF;
      smg_dp  <= DP_OFF;
    end else if (state == S_ON) begin
      smg_com <= (COM_ACT_LOW != 0) ? ~com_hot : com_hot;
      if (cur_blank) begin
        smg_seg <= SEG_OFF;
      end else begin
        smg_seg <= (SEG_ACT_LOW != 0) ? ~seg_hi : seg_hi;
      end
      smg_dp  <= (SEG_ACT_LOW != 0) ? ~cur_dp : cur_dp;
    end else begin
      smg_com <= COM_OFF;
      smg_seg <= SEG_OFF;
      smg_dp  <= DP_OFF;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: 4 digits, SCAN_DIV=10, FRESH_DIV=100,
// DEAD_CYC=2, active-low segments and commons. Cycle numbers below count
// rising edges since reset release; values are sampled 1 time unit after.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] i_data = '0;
  logic [3:0]  i_dp = '0;
  logic        i_blank_lz = 1'b0;
  logic        i_update = 1'b0;
  logic [6:0]  smg_seg;
  logic        smg_dp;
  logic [3:0]  smg_com;
  logic        o_frame;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  seg7_scan_ctrl #(
    .N_DIGITS   (4),
    .CLK_HZ     (100),
    .SCAN_HZ    (10),
    .FRESH_HZ   (1),
    .DEAD_CYC   (2),
    .SEG_ACT_LOW(1),
    .COM_ACT_LOW(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_data    (i_data),
    .i_dp      (i_dp),
    .i_blank_lz(i_blank_lz),
    .i_update  (i_update),
    .smg_seg   (smg_seg),
    .smg_dp    (smg_dp),
    .smg_com   (smg_com),
    .o_frame   (o_frame)
  );

  always #5 clk = ~clk;

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic goto(input int t);
    if (t > cyc) adv(t - cyc);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    adv(n);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic pulse_update();
    i_update = 1'b1;
    adv(1);
    i_update = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] com, input logic [6:0] seg,
                         input logic dp);
    check({tag, "_com"}, 32'(smg_com), 32'(com));
    check({tag, "_seg"}, 32'(smg_seg), 32'(seg));
    check({tag, "_dp"},  32'(smg_dp),  32'(dp));
  endtask

  initial begin
    // 1: reset values, first digit only after scan_tick + dead time
    do_reset(3);
    chk_out("rst", 4'hF, 7'h7F, 1'b1);
    check("rst_frame", 32'(o_frame), 32'd0);
    goto(12);
    check("first_dead_com", 32'(smg_com), 32'hF);
    goto(13);
    chk_out("first_on", 4'hE, 7'h40, 1'b1);

    // 2: scan order and decode after a requested load at the first frame boundary
    i_data = 16'h1234;
    i_dp = 4'h0;
    i_blank_lz = 1'b0;
    do_reset(3);
    pulse_update();
    goto(13);
    check("preload_seg", 32'(smg_seg), 32'h40);
    goto(49);
    check("frame_before", 32'(o_frame), 32'd0);
    goto(50);
    check("frame_pulse", 32'(o_frame), 32'd1);
    goto(51);
    check("frame_after", 32'(o_frame), 32'd0);
    goto(53);
    chk_out("scan_d0", 4'hE, 7'h19, 1'b1);
    goto(60);
    check("d0_last_on", 32'(smg_com), 32'hE);
    goto(61);
    chk_out("dead_a", 4'hF, 7'h7F, 1'b1);
    goto(62);
    check("dead_b", 32'(smg_com), 32'hF);
    goto(63);
    chk_out("scan_d1", 4'hD, 7'h30, 1'b1);
    goto(73);
    chk_out("scan_d2", 4'hB, 7'h24, 1'b1);
    goto(83);
    chk_out("scan_d3", 4'h7, 7'h79, 1'b1);

    // 3: mid-frame data change must not tear the frame in progress
    i_data = 16'h1234;
    do_reset(3);
    pulse_update();
    goto(65);
    i_data = 16'hABCD;
    pulse_update();
    goto(73);
    chk_out("tear_d2", 4'hB, 7'h24, 1'b1);
    goto(83);
    chk_out("tear_d3", 4'h7, 7'h79, 1'b1);
    goto(89);
    check("tear_frame_pre", 32'(o_frame), 32'd0);
    goto(90);
    check("tear_frame", 32'(o_frame), 32'd1);
    goto(91);
    check("tear_frame_post", 32'(o_frame), 32'd0);
    goto(93);
    chk_out("new_d0", 4'hE, 7'h21, 1'b1);
    goto(103);
    chk_out("new_d1", 4'hD, 7'h46, 1'b1);
    goto(113);
    chk_out("new_d2", 4'hB, 7'h03, 1'b1);
    goto(123);
    chk_out("new_d3", 4'h7, 7'h08, 1'b1);

    // 4: leading-zero blanking, and a dp on the top digit defeating it
    i_data = 16'h0070;
    i_dp = 4'h0;
    i_blank_lz = 1'b1;
    do_reset(3);
    pulse_update();
    goto(53);
    chk_out("lz_d0", 4'hE, 7'h40, 1'b1);
    goto(63);
    chk_out("lz_d1", 4'hD, 7'h78, 1'b1);
    goto(73);
    chk_out("lz_d2", 4'hB, 7'h7F, 1'b1);
    goto(83);
    chk_out("lz_d3", 4'h7, 7'h7F, 1'b1);
    goto(85);
    i_dp = 4'b1000;
    pulse_update();
    goto(93);
    chk_out("dp_d0", 4'hE, 7'h40, 1'b1);
    goto(103);
    chk_out("dp_d1", 4'hD, 7'h78, 1'b1);
    goto(113);
    chk_out("dp_d2", 4'hB, 7'h40, 1'b1);
    goto(123);
    chk_out("dp_d3", 4'h7, 7'h40, 1'b0);

    // 5: refresh tick alone requests the load; no earlier boundary loads
    i_data = 16'h0005;
    i_dp = 4'h0;
    i_blank_lz = 1'b0;
    do_reset(3);
    goto(50);
    check("fresh_f50", 32'(o_frame), 32'd0);
    goto(90);
    check("fresh_f90", 32'(o_frame), 32'd0);
    goto(93);
    check("fresh_old_seg", 32'(smg_seg), 32'h40);
    goto(129);
    check("fresh_f129", 32'(o_frame), 32'd0);
    goto(130);
    check("fresh_f130", 32'(o_frame), 32'd1);
    goto(133);
    chk_out("fresh_d0", 4'hE, 7'h12, 1'b1);
    goto(143);
    chk_out("fresh_d1", 4'hD, 7'h40, 1'b1);

    // 6: reset in the middle of digit 2's ON window
    goto(155);
    chk_out("mid_d2", 4'hB, 7'h40, 1'b1);
    do_reset(1);
    chk_out("mid_rst", 4'hF, 7'h7F, 1'b1);
    check("mid_rst_frame", 32'(o_frame), 32'd0);
    goto(12);
    check("mid_restart_dead", 32'(smg_com), 32'hF);
    goto(13);
    chk_out("mid_restart_d0", 4'hE, 7'h40, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
